// File: rtl/regfile_loader.sv
// Host-side stream loader: turns a valid/ready word stream of headers and payload into
// registered single-cycle writes on the InexRecur/state regfile ports and an is_start pulse.
module regfile_loader #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned INEX_W  = 32,
  parameter int unsigned STATE_W = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  output logic               ran_we_InexRecur,
  output logic [ADDR_W-1:0]  ran_w_addr_InexRecur,
  output logic [INEX_W-1:0]  ran_w_data_InexRecur,
  output logic               ran_we_state_external,
  output logic [ADDR_W-1:0]  ran_w_addr_state_external,
  output logic [STATE_W-1:0] ran_w_data_state_external,
  output logic               is_start,
  output logic               burst_done,
  output logic               busy,
  output logic               err
);

  typedef enum logic [1:0] {StIdle, StData, StStart} state_e;

  state_e              r_state, w_state;
  logic                r_tgt_state, w_tgt_state;
  logic [ADDR_W-1:0]   r_ptr, w_ptr;
  logic [11:0]         r_rem, w_rem;
  logic                r_we_inex, w_we_inex;
  logic [ADDR_W-1:0]   r_addr_inex, w_addr_inex;
  logic [INEX_W-1:0]   r_data_inex, w_data_inex;
  logic                r_we_state, w_we_state;
  logic [ADDR_W-1:0]   r_addr_state, w_addr_state;
  logic [STATE_W-1:0]  r_data_state, w_data_state;
  logic                r_start, w_start;
  logic                r_done, w_done;
  logic                r_err, w_err;
  logic                w_accept;

  // Gated by rst_n so the loader never advertises ready while held in reset.
  assign in_ready = (r_state != StStart) && rst_n;
  assign w_accept = in_valid && in_ready;
  assign busy     = (r_state == StData) || (r_state == StStart);

  always_comb begin
    w_state      = r_state;
    w_tgt_state  = r_tgt_state;
    w_ptr        = r_ptr;
    w_rem        = r_rem;
    w_we_inex    = 1'b0;
    w_addr_inex  = r_addr_inex;
    w_data_inex  = r_data_inex;
    w_we_state   = 1'b0;
    w_addr_state = r_addr_state;
    w_data_state = r_data_state;
    w_start      = 1'b0;
    w_done       = 1'b0;
    w_err        = r_err;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          unique case (in_data[31:30])
            2'b00, 2'b01: begin
              w_tgt_state = in_data[30];
              w_ptr       = in_data[ADDR_W-1:0];
              w_rem       = in_data[29:18];
              w_state     = StData;
            end
            2'b10: begin
              w_start = 1'b1;
              w_state = StStart;
            end
            default: w_err = 1'b1;
          endcase
        end
      end
      StData: begin
        if (w_accept) begin
          if (r_tgt_state) begin
            w_we_state   = 1'b1;
            w_addr_state = r_ptr;
            w_data_state = in_data[STATE_W-1:0];
            // Payload bits beyond the state width are a host error, but the write still lands.
            if (|in_data[31:STATE_W]) w_err = 1'b1;
          end else begin
            w_we_inex   = 1'b1;
            w_addr_inex = r_ptr;
            w_data_inex = in_data[INEX_W-1:0];
          end
          w_ptr = r_ptr + 1'b1;
          w_rem = r_rem - 12'd1;
          if (r_rem == 12'd0) begin
            w_done  = 1'b1;
            w_state = StIdle;
          end
        end
      end
      StStart: w_state = StIdle;
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_tgt_state  <= 1'b0;
      r_ptr        <= '0;
      r_rem        <= '0;
      r_we_inex    <= 1'b0;
      r_addr_inex  <= '0;
      r_data_inex  <= '0;
      r_we_state   <= 1'b0;
      r_addr_state <= '0;
      r_data_state <= '0;
      r_start      <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_tgt_state  <= w_tgt_state;
      r_ptr        <= w_ptr;
      r_rem        <= w_rem;
      r_we_inex    <= w_we_inex;
      r_addr_inex  <= w_addr_inex;
      r_data_inex  <= w_data_inex;
      r_we_state   <= w_we_state;
      r_addr_state <= w_addr_state;
      r_data_state <= w_data_state;
      r_start      <= w_start;
      r_done       <= w_done;
      r_err        <= w_err;
    end
  end

  assign ran_we_InexRecur          = r_we_inex;
  assign ran_w_addr_InexRecur      = r_addr_inex;
  assign ran_w_data_InexRecur      = r_data_inex;
  assign ran_we_state_external     = r_we_state;
  assign ran_w_addr_state_external = r_addr_state;
  assign ran_w_data_state_external = r_data_state;
  assign is_start                  = r_start;
  assign burst_done                = r_done;
  assign err                       = r_err;

endmodule
